// File: rtl/sc_ir_prefetch_queue_if.sv
// IR prefetch queue bus: push/pop/flush strobes in,
// decoded head instruction and occupancy flags out.
interface sc_ir_prefetch_queue_if #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int DATAWIDTH_SCRATCHPAD_DIRECTION = 5,
  parameter int DATAWIDTH_DECODEROP = 8,
  parameter int DATAWIDTH_COUNT = 3
);
  logic SC_IRQueue_load_InLow;
  logic SC_IRQueue_advance_InLow;
  logic SC_IRQueue_flush_InHigh;
  logic [DATAWIDTH_BUS-1:0] SC_IRQueue_data_InBus;
  logic [DATAWIDTH_BUS-1:0] SC_IRQueue_data_OutBus;
  logic SC_IRQueue_valid_OutHigh;
  logic [DATAWIDTH_SCRATCHPAD_DIRECTION-1:0] SC_IRQueue_RDestino_OutBus;
  logic [DATAWIDTH_SCRATCHPAD_DIRECTION-1:0] SC_IRQueue_RS1_OutBus;
  logic [DATAWIDTH_SCRATCHPAD_DIRECTION-1:0] SC_IRQueue_RS2_OutBus;
  logic [DATAWIDTH_DECODEROP-1:0] SC_IRQueue_OPS_OutBus;
  logic SC_IRQueue_BIT13_OutBus;
  logic [DATAWIDTH_BUS-1:0] SC_IRQueue_SIMM13_OutBus;
  logic SC_IRQueue_full_OutHigh;
  logic SC_IRQueue_empty_OutHigh;
  logic [DATAWIDTH_COUNT-1:0] SC_IRQueue_count_OutBus;
  logic SC_IRQueue_overflow_OutHigh;

  modport master (
    output SC_IRQueue_load_InLow,
    output SC_IRQueue_advance_InLow,
    output SC_IRQueue_flush_InHigh,
    output SC_IRQueue_data_InBus,
    input  SC_IRQueue_data_OutBus,
    input  SC_IRQueue_valid_OutHigh,
    input  SC_IRQueue_RDestino_OutBus,
    input  SC_IRQueue_RS1_OutBus,
    input  SC_IRQueue_RS2_OutBus,
    input  SC_IRQueue_OPS_OutBus,
    input  SC_IRQueue_BIT13_OutBus,
    input  SC_IRQueue_SIMM13_OutBus,
    input  SC_IRQueue_full_OutHigh,
    input  SC_IRQueue_empty_OutHigh,
    input  SC_IRQueue_count_OutBus,
    input  SC_IRQueue_overflow_OutHigh
  );

  modport slave (
    input  SC_IRQueue_load_InLow,
    input  SC_IRQueue_advance_InLow,
    input  SC_IRQueue_flush_InHigh,
    input  SC_IRQueue_data_InBus,
    output SC_IRQueue_data_OutBus,
    output SC_IRQueue_valid_OutHigh,
    output SC_IRQueue_RDestino_OutBus,
    output SC_IRQueue_RS1_OutBus,
    output SC_IRQueue_RS2_OutBus,
    output SC_IRQueue_OPS_OutBus,
    output SC_IRQueue_BIT13_OutBus,
    output SC_IRQueue_SIMM13_OutBus,
    output SC_IRQueue_full_OutHigh,
    output SC_IRQueue_empty_OutHigh,
    output SC_IRQueue_count_OutBus,
    output SC_IRQueue_overflow_OutHigh
  );
endinterface

// File: rtl/sc_ir_prefetch_queue.sv
// DEPTH-entry instruction prefetch queue; head entry is the
// current IR, decoded into register/opcode/immediate fields.
module sc_ir_prefetch_queue #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int DATAWIDTH_SCRATCHPAD_DIRECTION = 5,
  parameter int DATAWIDTH_DECODEROP = 8,
  parameter int DEPTH = 4,
  parameter int DATAWIDTH_COUNT = 3
) (
  input logic SC_IRQueue_CLOCK_50,
  input logic SC_IRQueue_RESET_InLow,
  sc_ir_prefetch_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [DATAWIDTH_COUNT-1:0] FULLCNT =
    DATAWIDTH_COUNT'(DEPTH);

  logic [DATAWIDTH_BUS-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [DATAWIDTH_COUNT-1:0] count;
  logic overflow;
  logic popOk;
  logic pushOk;
  logic dropPush;
  logic headValid;
  logic [DATAWIDTH_BUS-1:0] head;
  logic [31:0] ir;

  // A pop frees the tail slot in the same edge, so push at full is legal then.
  always_comb begin
    popOk = !q.SC_IRQueue_advance_InLow && (count != '0);
    pushOk = !q.SC_IRQueue_load_InLow &&
      ((count != FULLCNT) || popOk);
    dropPush = !q.SC_IRQueue_load_InLow && !pushOk;
  end

  always_ff @(posedge SC_IRQueue_CLOCK_50 or negedge SC_IRQueue_RESET_InLow) begin
    if (!SC_IRQueue_RESET_InLow) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!q.SC_IRQueue_flush_InHigh && pushOk) begin
      mem[wrPtr] <= q.SC_IRQueue_data_InBus;
    end
  end

  always_ff @(posedge SC_IRQueue_CLOCK_50 or negedge SC_IRQueue_RESET_InLow) begin
    if (!SC_IRQueue_RESET_InLow) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else if (q.SC_IRQueue_flush_InHigh) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popOk) rdPtr <= rdPtr + 1'b1;
      if (pushOk && !popOk) count <= count + 1'b1;
      else if (popOk && !pushOk) count <= count - 1'b1;
      if (dropPush) overflow <= 1'b1;
    end
  end

  always_comb begin
    headValid = (count != '0);
    head = headValid ? mem[rdPtr] : '0;
    ir = head[31:0];
  end

  assign q.SC_IRQueue_data_OutBus = head;
  assign q.SC_IRQueue_valid_OutHigh = headValid;
  assign q.SC_IRQueue_RDestino_OutBus =
    DATAWIDTH_SCRATCHPAD_DIRECTION'(ir[29:25]);
  assign q.SC_IRQueue_RS1_OutBus =
    DATAWIDTH_SCRATCHPAD_DIRECTION'(ir[18:14]);
  assign q.SC_IRQueue_RS2_OutBus =
    DATAWIDTH_SCRATCHPAD_DIRECTION'(ir[4:0]);
  assign q.SC_IRQueue_OPS_OutBus =
    DATAWIDTH_DECODEROP'({ir[31:30], ir[24:19]});
  assign q.SC_IRQueue_BIT13_OutBus = ir[13];
  assign q.SC_IRQueue_SIMM13_OutBus =
    {{(DATAWIDTH_BUS-13){ir[12]}}, ir[12:0]};
  assign q.SC_IRQueue_full_OutHigh = (count == FULLCNT);
  assign q.SC_IRQueue_empty_OutHigh = (count == '0);
  assign q.SC_IRQueue_count_OutBus = count;
  assign q.SC_IRQueue_overflow_OutHigh = overflow;
endmodule

// File: tb/tb_sc_ir_prefetch_queue.sv
// Directed bench for sc_ir_prefetch_queue with
// hand-computed expected values.
module tb_sc_ir_prefetch_queue;
  logic clk;
  logic rst_n;
  int nCmp;
  int nBad;

  sc_ir_prefetch_queue_if bus();

  sc_ir_prefetch_queue dut (
    .SC_IRQueue_CLOCK_50(clk),
    .SC_IRQueue_RESET_InLow(rst_n),
    .q(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.SC_IRQueue_load_InLow = 1'b1;
    bus.SC_IRQueue_advance_InLow = 1'b1;
    bus.SC_IRQueue_flush_InHigh = 1'b0;
    bus.SC_IRQueue_data_InBus = '0;
  endtask

  // Drive one cycle, then sample 1 time unit after the edge.
  task automatic cyc(input logic ld, input logic adv,
                     input logic fl, input logic [31:0] d);
    bus.SC_IRQueue_load_InLow = ld;
    bus.SC_IRQueue_advance_InLow = adv;
    bus.SC_IRQueue_flush_InHigh = fl;
    bus.SC_IRQueue_data_InBus = d;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push(input logic [31:0] d);
    cyc(1'b0, 1'b1, 1'b0, d);
  endtask

  task automatic pop();
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic chkState(input string tag, input int cnt,
                          input logic ov);
    chk({tag, ".count"}, 32'(bus.SC_IRQueue_count_OutBus), 32'(cnt));
    chk({tag, ".empty"}, 32'(bus.SC_IRQueue_empty_OutHigh), 32'(cnt == 0));
    chk({tag, ".full"}, 32'(bus.SC_IRQueue_full_OutHigh), 32'(cnt == 4));
    chk({tag, ".valid"}, 32'(bus.SC_IRQueue_valid_OutHigh), 32'(cnt != 0));
    chk({tag, ".ovf"}, 32'(bus.SC_IRQueue_overflow_OutHigh), 32'(ov));
  endtask

  logic [31:0] w5 [5];
  logic [31:0] expA [10];

  initial begin
    nCmp = 0;
    nBad = 0;
    idle();
    rst_n = 1'b0;
    #22;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      chkState("rst", 0, 1'b0);
      chk("rst.data", bus.SC_IRQueue_data_OutBus, 32'h0);
      chk("rst.simm", bus.SC_IRQueue_SIMM13_OutBus, 32'h0);
      chk("rst.ops", 32'(bus.SC_IRQueue_OPS_OutBus), 32'h0);
      chk("rst.rd", 32'(bus.SC_IRQueue_RDestino_OutBus), 32'h0);
      @(posedge clk);
      #1;
    end

    // 0x8A106005: op=10 rd=00101 op3=000010 rs1=00001 i=1 simm=5
    push(32'h8A10_6005);
    chkState("dec1", 1, 1'b0);
    chk("dec1.data", bus.SC_IRQueue_data_OutBus, 32'h8A10_6005);
    chk("dec1.rd", 32'(bus.SC_IRQueue_RDestino_OutBus), 32'd5);
    chk("dec1.rs1", 32'(bus.SC_IRQueue_RS1_OutBus), 32'd1);
    chk("dec1.rs2", 32'(bus.SC_IRQueue_RS2_OutBus), 32'd5);
    chk("dec1.ops", 32'(bus.SC_IRQueue_OPS_OutBus), 32'h82);
    chk("dec1.b13", 32'(bus.SC_IRQueue_BIT13_OutBus), 32'd1);
    chk("dec1.simm", bus.SC_IRQueue_SIMM13_OutBus, 32'h0000_0005);
    push(32'h8200_7FFF);
    chkState("dec2a", 2, 1'b0);
    pop();
    chkState("dec2", 1, 1'b0);
    chk("dec2.simm", bus.SC_IRQueue_SIMM13_OutBus, 32'hFFFF_FFFF);
    chk("dec2.rd", 32'(bus.SC_IRQueue_RDestino_OutBus), 32'd1);
    chk("dec2.ops", 32'(bus.SC_IRQueue_OPS_OutBus), 32'h80);
    chk("dec2.b13", 32'(bus.SC_IRQueue_BIT13_OutBus), 32'd1);
    pop();
    chkState("dec.drain", 0, 1'b0);
    pop();
    chkState("popEmpty", 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'hCAFE_0001);
    chkState("pushPopEmpty", 1, 1'b0);
    chk("pushPopEmpty.data", bus.SC_IRQueue_data_OutBus, 32'hCAFE_0001);
    pop();
    chkState("ppe.drain", 0, 1'b0);

    w5[0] = 32'h1111_1111;
    w5[1] = 32'h2222_2222;
    w5[2] = 32'h3333_3333;
    w5[3] = 32'h4444_4444;
    w5[4] = 32'h5555_5555;
    for (int i = 0; i < 4; i++) push(w5[i]);
    chkState("fill", 4, 1'b0);
    push(w5[4]);
    chkState("ovf", 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf.order", bus.SC_IRQueue_data_OutBus, w5[i]);
      pop();
    end
    chkState("ovf.drain", 0, 1'b1);

    cyc(1'b1, 1'b1, 1'b1, 32'h0);
    chkState("flushOvf", 0, 1'b0);

    for (int i = 0; i < 4; i++) expA[i] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 6; i++) expA[4 + i] = 32'hB000_0000 + 32'(i);
    for (int i = 0; i < 4; i++) push(expA[i]);
    for (int i = 0; i < 6; i++) begin
      chk("wrap.head", bus.SC_IRQueue_data_OutBus, expA[i]);
      cyc(1'b0, 1'b0, 1'b0, expA[4 + i]);
      chkState("wrap", 4, 1'b0);
    end
    for (int i = 6; i < 10; i++) begin
      chk("wrap.tail", bus.SC_IRQueue_data_OutBus, expA[i]);
      pop();
    end
    chkState("wrap.drain", 0, 1'b0);

    for (int i = 0; i < 4; i++) push(32'hC000_0000 + 32'(i));
    push(32'hC000_00FF);
    pop();
    chkState("pre.flush", 3, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chkState("flush", 0, 1'b0);
    chk("flush.data", bus.SC_IRQueue_data_OutBus, 32'h0);
    @(posedge clk);
    #1;
    chkState("flush.hold", 0, 1'b0);

    push(32'hE000_0001);
    push(32'hE000_0002);
    chkState("pre.rst", 2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chkState("asyncRst", 0, 1'b0);
    chk("asyncRst.data", bus.SC_IRQueue_data_OutBus, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(32'h0100_0000);
    chkState("postRst", 1, 1'b0);
    chk("postRst.data", bus.SC_IRQueue_data_OutBus, 32'h0100_0000);
    chk("postRst.ops", 32'(bus.SC_IRQueue_OPS_OutBus), 32'h20);
    chk("postRst.rd", 32'(bus.SC_IRQueue_RDestino_OutBus), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
